// File: rtl/f0_clc_gen.sv
// f0_clc_gen: fetch stage 0 cacheline-counter generator with next-line and BP-hint prefetch outputs.
// Define F0_BPPF_FIFO_EN for a BPPF_DEPTH-entry hint FIFO; otherwise hints use a single register.
module f0_clc_gen #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
  parameter int          NLPF_DIST    = 1,
  parameter int          BPPF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        resteer_valid,
  input  logic [31:0] resteer_addr,
  input  logic        bp_valid,
  input  logic [31:0] bp_target,
  input  logic        bppf_req_valid,
  input  logic [31:0] bppf_req_addr,
  output logic [25:0] cacheline_counter_out,
  output logic        clc_valid,
  output logic [25:0] nlpf,
  output logic        nlpf_valid,
  output logic [25:0] bppf,
  output logic        bppf_valid,
  output logic        bppf_full
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, REDIRECT = 2'd2} state_t;

  localparam logic [25:0] RESET_LINE = RESET_VECTOR[31:6];
  localparam logic [25:0] NLPF_INC   = 26'(NLPF_DIST);

  if (NLPF_DIST < 1 || NLPF_DIST > 7 || BPPF_DEPTH < 1 || (BPPF_DEPTH & (BPPF_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("f0_clc_gen: unsupported NLPF_DIST or BPPF_DEPTH");
  end

  state_t      state, state_next;
  logic [25:0] line_next;
  logic        clc_valid_next, nlpf_valid_next;
  logic        push, pop;
  logic [25:0] req_line;
  logic        unused_offset_bits;

  assign req_line           = bppf_req_addr[31:6];
  assign unused_offset_bits = ^{resteer_addr[5:0], bp_target[5:0], bppf_req_addr[5:0]};

  // A resteer flushes the hint storage and suppresses any same-cycle push or pop.
  assign push = bppf_req_valid && !bppf_full && !resteer_valid;
  assign pop  = bppf_valid && !stall_in && !resteer_valid;

  // Next-state and next-counter selection; resteer beats prediction and advance.
  always_comb begin
    state_next      = state;
    line_next       = cacheline_counter_out;
    clc_valid_next  = clc_valid;
    nlpf_valid_next = nlpf_valid;
    if (resteer_valid) begin
      state_next      = REDIRECT;
      line_next       = resteer_addr[31:6];
      clc_valid_next  = 1'b0;
      nlpf_valid_next = 1'b0;
    end else begin
      case (state)
        IDLE, REDIRECT: begin
          state_next      = FETCH;
          clc_valid_next  = 1'b1;
          nlpf_valid_next = 1'b1;
        end
        FETCH: begin
          if (!stall_in) begin
            line_next       = bp_valid ? bp_target[31:6] : cacheline_counter_out + 26'd1;
            // A predicted-taken line gets no next-line prefetch.
            nlpf_valid_next = !bp_valid;
          end else begin
            line_next = cacheline_counter_out;
          end
        end
        default: begin
          state_next      = IDLE;
          clc_valid_next  = 1'b0;
          nlpf_valid_next = 1'b0;
        end
      endcase
    end
  end

  // Fetch pointer and its registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      cacheline_counter_out <= RESET_LINE;
      clc_valid             <= 1'b0;
      nlpf                  <= RESET_LINE + NLPF_INC;
      nlpf_valid            <= 1'b0;
    end else begin
      state                 <= state_next;
      cacheline_counter_out <= line_next;
      clc_valid             <= clc_valid_next;
      nlpf                  <= line_next + NLPF_INC;
      nlpf_valid            <= nlpf_valid_next;
    end
  end

`ifdef F0_BPPF_FIFO_EN
  localparam int               PTR_W     = (BPPF_DEPTH > 1) ? $clog2(BPPF_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(BPPF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BPPF_DEPTH - 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [25:0]      mem [BPPF_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [PTR_W:0]   count, count_next;
  logic [25:0]      bppf_next;

  // Pointer/count update and look-ahead of the head entry so bppf stays registered.
  always_comb begin
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;
    if (resteer_valid) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      rd_ptr_next = pop ? ptr_inc(rd_ptr) : rd_ptr;
      wr_ptr_next = push ? ptr_inc(wr_ptr) : wr_ptr;
      if (push && !pop) begin
        count_next = count + (PTR_W + 1)'(1);
      end else if (!push && pop) begin
        count_next = count - (PTR_W + 1)'(1);
      end else begin
        count_next = count;
      end
    end
    if (count_next == '0) begin
      bppf_next = '0;
    end else if (push && (wr_ptr == rd_ptr_next)) begin
      bppf_next = req_line;
    end else begin
      bppf_next = mem[rd_ptr_next];
    end
  end

  // Hint storage array; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= req_line;
    end
  end

  // FIFO bookkeeping and registered hint outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      bppf       <= '0;
      bppf_valid <= 1'b0;
      bppf_full  <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr_next;
      wr_ptr     <= wr_ptr_next;
      count      <= count_next;
      bppf       <= bppf_next;
      bppf_valid <= (count_next != '0);
      bppf_full  <= (count_next == DEPTH_CNT);
    end
  end
`else
  logic        hold_valid_next;
  logic [25:0] bppf_next;

  // Single-entry hint holder: full whenever occupied.
  always_comb begin
    hold_valid_next = bppf_valid;
    bppf_next       = bppf;
    if (resteer_valid) begin
      hold_valid_next = 1'b0;
      bppf_next       = '0;
    end else if (push) begin
      hold_valid_next = 1'b1;
      bppf_next       = req_line;
    end else if (pop) begin
      hold_valid_next = 1'b0;
      bppf_next       = '0;
    end else begin
      hold_valid_next = bppf_valid;
      bppf_next       = bppf;
    end
  end

  // Registered hint outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bppf       <= '0;
      bppf_valid <= 1'b0;
      bppf_full  <= 1'b0;
    end else begin
      bppf       <= bppf_next;
      bppf_valid <= hold_valid_next;
      bppf_full  <= hold_valid_next;
    end
  end
`endif

endmodule

// File: tb/tb_f0_clc_gen.sv
// Self-checking bench for f0_clc_gen: directed test-plan scenarios plus randomized traffic
// against a queue-based reference model.
module tb_f0_clc_gen;

`ifdef F0_BPPF_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, stall_in, resteer_valid, bp_valid, bppf_req_valid;
  logic [31:0] resteer_addr, bp_target, bppf_req_addr;
  logic [25:0] cacheline_counter_out, nlpf, bppf;
  logic        clc_valid, nlpf_valid, bppf_valid, bppf_full;

  int nchk = 0;
  int nfail = 0;

  // reference model
  int          m_state;  // 0 idle, 1 fetch, 2 redirect
  logic [25:0] m_line, m_nl, m_bppf;
  logic        m_cv, m_nlv;
  logic [25:0] m_q[$];

  f0_clc_gen dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .resteer_valid(resteer_valid), .resteer_addr(resteer_addr),
    .bp_valid(bp_valid), .bp_target(bp_target),
    .bppf_req_valid(bppf_req_valid), .bppf_req_addr(bppf_req_addr),
    .cacheline_counter_out(cacheline_counter_out), .clc_valid(clc_valid),
    .nlpf(nlpf), .nlpf_valid(nlpf_valid),
    .bppf(bppf), .bppf_valid(bppf_valid), .bppf_full(bppf_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    stall_in = 1'b0; resteer_valid = 1'b0; resteer_addr = 32'h0;
    bp_valid = 1'b0; bp_target = 32'h0; bppf_req_valid = 1'b0; bppf_req_addr = 32'h0;
  endtask

  // one clock edge: model consumes the inputs seen at the edge, then settle
  task automatic cycle();
    bit full;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_line = 26'h40; m_cv = 1'b0; m_nlv = 1'b0;
      m_q.delete();
    end else begin
      full = (m_q.size() == CAP);
      if (resteer_valid) begin
        m_q.delete();
        m_line = resteer_addr[31:6]; m_state = 2; m_cv = 1'b0; m_nlv = 1'b0;
      end else begin
        if (m_q.size() != 0 && !stall_in) void'(m_q.pop_front());
        if (bppf_req_valid && !full) m_q.push_back(bppf_req_addr[31:6]);
        if (m_state != 1) begin
          m_state = 1; m_cv = 1'b1; m_nlv = 1'b1;
        end else if (!stall_in) begin
          m_line = bp_valid ? bp_target[31:6] : m_line + 26'd1;
          m_nlv  = !bp_valid;
        end
      end
    end
    m_nl   = m_line + 26'd1;
    m_bppf = (m_q.size() != 0) ? m_q[0] : 26'h0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    cycle(); cycle();
    nchk++; if (cacheline_counter_out !== 26'h40) begin nfail++; $display("FAIL reset_line: got %h want 40", cacheline_counter_out); end
    nchk++; if (clc_valid !== 1'b0) begin nfail++; $display("FAIL reset_clc_valid: got %b want 0", clc_valid); end
    nchk++; if (nlpf !== 26'h41) begin nfail++; $display("FAIL reset_nlpf: got %h want 41", nlpf); end
    nchk++; if (nlpf_valid !== 1'b0) begin nfail++; $display("FAIL reset_nlpf_valid: got %b want 0", nlpf_valid); end
    nchk++; if (bppf !== 26'h0) begin nfail++; $display("FAIL reset_bppf: got %h want 0", bppf); end
    nchk++; if (bppf_valid !== 1'b0) begin nfail++; $display("FAIL reset_bppf_valid: got %b want 0", bppf_valid); end
    nchk++; if (bppf_full !== 1'b0) begin nfail++; $display("FAIL reset_bppf_full: got %b want 0", bppf_full); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      nchk++; if (clc_valid !== 1'b1) begin nfail++; $display("FAIL start_valid[%0d]: got %b want 1", i, clc_valid); end
      nchk++; if (cacheline_counter_out !== 26'h40 + 26'(i)) begin nfail++; $display("FAIL start_line[%0d]: got %h want %h", i, cacheline_counter_out, 26'h40 + 26'(i)); end
      nchk++; if (nlpf !== 26'h41 + 26'(i)) begin nfail++; $display("FAIL start_nlpf[%0d]: got %h want %h", i, nlpf, 26'h41 + 26'(i)); end
    end
  endtask

  task automatic test_wrap();
    resteer_valid = 1'b1; resteer_addr = 32'hFFFF_FFC0;
    cycle();
    resteer_valid = 1'b0;
    nchk++; if (clc_valid !== 1'b0) begin nfail++; $display("FAIL wrap_redirect_valid: got %b want 0", clc_valid); end
    nchk++; if (cacheline_counter_out !== 26'h3FF_FFFF) begin nfail++; $display("FAIL wrap_redirect_line: got %h want 3ffffff", cacheline_counter_out); end
    nchk++; if (nlpf !== 26'h0) begin nfail++; $display("FAIL wrap_nlpf_early: got %h want 0", nlpf); end
    cycle();
    nchk++; if (clc_valid !== 1'b1 || cacheline_counter_out !== 26'h3FF_FFFF) begin nfail++; $display("FAIL wrap_fetch_top: got %b/%h want 1/3ffffff", clc_valid, cacheline_counter_out); end
    cycle();
    nchk++; if (cacheline_counter_out !== 26'h0) begin nfail++; $display("FAIL wrap_line_zero: got %h want 0", cacheline_counter_out); end
    nchk++; if (nlpf !== 26'h1) begin nfail++; $display("FAIL wrap_nlpf_one: got %h want 1", nlpf); end
  endtask

  task automatic test_bp();
    bp_valid = 1'b1; bp_target = 32'h0000_8000;
    cycle();
    bp_valid = 1'b0;
    nchk++; if (cacheline_counter_out !== 26'h200) begin nfail++; $display("FAIL bp_line: got %h want 200", cacheline_counter_out); end
    nchk++; if (nlpf_valid !== 1'b0) begin nfail++; $display("FAIL bp_nlpf_valid: got %b want 0", nlpf_valid); end
    cycle();
    nchk++; if (cacheline_counter_out !== 26'h201 || nlpf_valid !== 1'b1) begin nfail++; $display("FAIL bp_after: got %h/%b want 201/1", cacheline_counter_out, nlpf_valid); end
  endtask

  task automatic test_stall_resteer();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bppf_req_valid = 1'b1; bppf_req_addr = {26'h3000 + 26'(i), 6'h0};
      cycle();
      nchk++; if (cacheline_counter_out !== 26'h201 || clc_valid !== 1'b1 || nlpf !== 26'h202 || nlpf_valid !== 1'b1) begin
        nfail++; $display("FAIL stall_frozen[%0d]: got %h/%b/%h/%b want 201/1/202/1", i, cacheline_counter_out, clc_valid, nlpf, nlpf_valid);
      end
      nchk++; if (bppf_valid !== 1'b1 || bppf !== 26'h3000) begin nfail++; $display("FAIL stall_push[%0d]: got %b/%h want 1/3000", i, bppf_valid, bppf); end
    end
    resteer_valid = 1'b1; resteer_addr = 32'h0002_0040;
    cycle();
    resteer_valid = 1'b0; stall_in = 1'b0; bppf_req_valid = 1'b0;
    nchk++; if (clc_valid !== 1'b0 || cacheline_counter_out !== 26'h801) begin nfail++; $display("FAIL resteer_redirect: got %b/%h want 0/801", clc_valid, cacheline_counter_out); end
    nchk++; if (bppf_valid !== 1'b0 || bppf_full !== 1'b0) begin nfail++; $display("FAIL resteer_flush: got %b/%b want 0/0", bppf_valid, bppf_full); end
    cycle();
    nchk++; if (clc_valid !== 1'b1 || cacheline_counter_out !== 26'h801) begin nfail++; $display("FAIL resteer_fetch: got %b/%h want 1/801", clc_valid, cacheline_counter_out); end
  endtask

  task automatic test_fifo_full();
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bppf_req_valid = 1'b1; bppf_req_addr = {26'h100 + 26'(i), 6'h15};
      cycle();
      nchk++; if (bppf_full !== ((i + 1) >= CAP)) begin nfail++; $display("FAIL fill_full[%0d]: got %b want %b", i, bppf_full, (i + 1) >= CAP); end
      nchk++; if (bppf_valid !== 1'b1 || bppf !== 26'h100) begin nfail++; $display("FAIL fill_head[%0d]: got %b/%h want 1/100", i, bppf_valid, bppf); end
    end
    bppf_req_valid = 1'b0; stall_in = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      nchk++; if (bppf_valid !== 1'b1 || bppf !== 26'h100 + 26'(i)) begin nfail++; $display("FAIL drain[%0d]: got %b/%h want 1/%h", i, bppf_valid, bppf, 26'h100 + 26'(i)); end
      cycle();
    end
    nchk++; if (bppf_valid !== 1'b0 || bppf_full !== 1'b0) begin nfail++; $display("FAIL drain_empty: got %b/%b want 0/0", bppf_valid, bppf_full); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(199) == 0);
      resteer_valid  = ($urandom_range(15) == 0);
      resteer_addr   = ($urandom_range(7) == 0) ? (32'hFFFF_FF80 | ($urandom & 32'h7F)) : $urandom;
      stall_in       = ($urandom_range(2) == 0);
      bp_valid       = ($urandom_range(3) == 0);
      bp_target      = $urandom;
      bppf_req_valid = $urandom_range(1) == 1;
      bppf_req_addr  = $urandom;
      cycle();
      nchk++; if (cacheline_counter_out !== m_line) begin nfail++; $display("FAIL rand_line c%0d: got %h want %h", c, cacheline_counter_out, m_line); end
      nchk++; if (clc_valid !== m_cv) begin nfail++; $display("FAIL rand_clc_valid c%0d: got %b want %b", c, clc_valid, m_cv); end
      nchk++; if (nlpf !== m_nl) begin nfail++; $display("FAIL rand_nlpf c%0d: got %h want %h", c, nlpf, m_nl); end
      nchk++; if (nlpf_valid !== m_nlv) begin nfail++; $display("FAIL rand_nlpf_valid c%0d: got %b want %b", c, nlpf_valid, m_nlv); end
      nchk++; if (bppf_valid !== (m_q.size() != 0)) begin nfail++; $display("FAIL rand_bppf_valid c%0d: got %b want %b", c, bppf_valid, m_q.size() != 0); end
      nchk++; if (bppf_full !== (m_q.size() == CAP)) begin nfail++; $display("FAIL rand_bppf_full c%0d: got %b want %b", c, bppf_full, m_q.size() == CAP); end
      if (m_q.size() != 0) begin
        nchk++; if (bppf !== m_bppf) begin nfail++; $display("FAIL rand_bppf c%0d: got %h want %h", c, bppf, m_bppf); end
      end
    end
    idle_inputs(); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_bp();
    test_stall_resteer();
    test_fifo_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/f0_clc_gen.md
# f0_clc_gen

Frontend stage 0: fetch cacheline-counter generator. It owns the architectural fetch line pointer and produces the current cacheline counter, a next-line prefetch line and a branch-predictor prefetch line. Backend resteers and branch-predictor taken targets redirect it. It sits directly upstream of the f1 stage and drives f1's `cacheline_counter_in`, `nlpf` and `bppf` inputs with registered values.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_1000, byte address of the first fetch; the line is `RESET_VECTOR[31:6]`.
- `NLPF_DIST`, 1, next-line prefetch distance in lines (1..7).
- `BPPF_DEPTH`, 4, BP prefetch FIFO depth, power of two. Only used with `F0_BPPF_FIFO_EN`.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_in` in 1: f1 cannot accept; hold all outputs.
- `resteer_valid` in 1: backend redirect (mispredict/exception).
- `resteer_addr` in 32: redirect byte address.
- `bp_valid` in 1: predictor says the current line ends in a taken branch.
- `bp_target` in 32: taken-branch target byte address.
- `bppf_req_valid` in 1: predictor prefetch hint.
- `bppf_req_addr` in 32: hint byte address.
- `cacheline_counter_out` out 26: current fetch line, which feeds f1 `cacheline_counter_in`.
- `clc_valid` out 1: `cacheline_counter_out` is a real fetch.
- `nlpf` out 26: next-line prefetch line.
- `nlpf_valid` out 1.
- `bppf` out 26: BP prefetch line.
- `bppf_valid` out 1.
- `bppf_full` out 1: hint storage full; new hints are dropped.

## Operation
- Line address is `addr[31:6]` (64 B lines). All line arithmetic is mod 2^26, so 26'h3FF_FFFF + 1 = 0.
- FSM states: IDLE, FETCH, REDIRECT.
  - IDLE is entered on reset. `clc_valid`=0 and the counter is `RESET_VECTOR[31:6]`. It always goes to FETCH on the next cycle.
  - FETCH: `clc_valid`=1. Advance when `!stall_in`.
    - Next counter is `bp_target[31:6]` if `bp_valid`, else counter+1.
    - `bp_valid` is ignored when not advancing.
  - REDIRECT: `clc_valid`=0 for exactly one cycle. The counter already holds the resteer line. It always goes to FETCH.
- A resteer is taken in any state, including during a stall and in IDLE.
  - The counter loads `resteer_addr[31:6]` and the state goes to REDIRECT.
  - It has priority over `bp_valid` and over advance.
- `nlpf` = counter + `NLPF_DIST`.
- `nlpf_valid` = `clc_valid && !bp_valid`, i.e. no next-line prefetch on a predicted-taken line.
- BP hints:
  - Push when `bppf_req_valid && !bppf_full`; otherwise the hint is dropped.
  - Pop when `bppf_valid && !stall_in`.
  - `bppf` is the head entry and `bppf_valid` = not empty.
  - A resteer flushes all entries, and a hint pushed in the same cycle is dropped.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - `cacheline_counter_out`=`RESET_VECTOR[31:6]`
  - `clc_valid`=0
  - `nlpf`=`RESET_VECTOR[31:6]`+`NLPF_DIST`
  - `nlpf_valid`=0
  - `bppf`=0
  - `bppf_valid`=0
  - `bppf_full`=0
- The first valid fetch appears on the 2nd cycle after `rst` deasserts.
- Sequential advance: 1 line per unstalled cycle. The new value is visible the cycle after the advancing edge.
- Resteer sampled at edge N:
  - N+1: REDIRECT, `clc_valid`=0, FIFO empty.
  - N+2: `clc_valid`=1 with the resteer line.
- Stall: outputs are bit-identical while `stall_in`=1. No pop happens, but pushes still occur.
- Hint pushed at edge N into an empty FIFO is visible on `bppf` at N+1.
- Simultaneous push and pop when not full: both happen and the count is unchanged.
- A push when full is rejected even if a pop happens in the same cycle.
- `bppf_full` reflects the count after the edge.
- `rst` mid-operation overrides everything: it clears the FIFO and returns to IDLE.

## Configuration
- `F0_BPPF_FIFO_EN` defined: hint storage is a `BPPF_DEPTH`-entry circular FIFO with wrap-around pointers and a count.
- `F0_BPPF_FIFO_EN` undefined: hint storage is a single register.
  - Full when occupied.
  - Same push, pop and flush rules as the FIFO.
  - `BPPF_DEPTH` is ignored.

## Test plan
- Reset release with default parameters and no stall → IDLE 1 cycle, then `cacheline_counter_out` 0x40, 0x41, 0x42 on successive cycles. `nlpf` is 0x41, 0x42, 0x43.
- Counter at 26'h3FF_FFFF, no stall → next is 0. `nlpf` wraps to 0 one cycle earlier.
- `bp_valid`=1, `bp_target`=32'h0000_8000 while advancing → next line 0x200. `nlpf_valid`=0 in the `bp_valid` cycle.
- `stall_in` held 3 cycles, then `resteer_addr`=32'h0002_0040 during the stall → outputs frozen during the stall. The next cycle has `clc_valid`=0, the one after has line 0x801 valid. Hints are flushed.
- 5 hints pushed back-to-back under stall (FIFO enabled, depth 4) → `bppf_full`=1 after the 4th and the 5th is dropped. After the stall releases, the 4 lines drain in order, one per cycle.
- Macro undefined: 2 back-to-back hints → only the first is held, and `bppf_valid` drops after one unstalled cycle.
